// File: rtl/acc_unit_8b_pkg.sv
// Shared definitions for the 8-bit accumulator stage: op codes and FSM encoding.
package acc_unit_8b_pkg;

  localparam int ACC_W = 8;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic is_sub(input logic [1:0] op);
    return op == OP_SUB;
  endfunction

endpackage

// File: rtl/acc_unit_8b_addsub.sv
// 8-bit ripple-carry adder/subtractor: s=1 computes a8 - b8 as a8 + ~b8 + 1.
module acc_unit_8b_addsub
  import acc_unit_8b_pkg::*;
(
  input  logic [ACC_W-1:0] a8,
  input  logic [ACC_W-1:0] b8,
  input  logic             s,
  output logic [ACC_W-1:0] sum8,
  output logic             cout8
);

  logic carry;
  logic bx;

  always_comb begin
    sum8  = '0;
    carry = s;
    bx    = 1'b0;
    for (int i = 0; i < ACC_W; i++) begin
      bx      = b8[i] ^ s;
      sum8[i] = a8[i] ^ bx ^ carry;
      carry   = (a8[i] & bx) | (carry & (a8[i] ^ bx));
    end
    cout8 = carry;
  end

endmodule

// File: rtl/acc_unit_8b.sv
// Accumulator register/control stage around the add/sub datapath, with
// valid/ready handshakes on both sides and registered result/flags.
module acc_unit_8b
  import acc_unit_8b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic [7:0]       ops_cnt
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [ACC_W-1:0] data_q;
  logic [ACC_W-1:0] acc_q;
  logic             c_q, z_q, v_q;
  logic [7:0]       cnt_q;
  logic             in_ready_q, out_valid_q;

  logic [ACC_W-1:0] sum;
  logic             cout;
  logic             sub;
  logic [ACC_W-1:0] b_eff;
  logic [ACC_W-1:0] acc_d;
  logic             c_d, v_d;

  assign sub = is_sub(op_q);

  acc_unit_8b_addsub u_addsub (
    .a8    (acc_q),
    .b8    (data_q),
    .s     (sub),
    .sum8  (sum),
    .cout8 (cout)
  );

  // Operand as the adder actually sees it, needed for the overflow rule.
  assign b_eff = data_q ^ {ACC_W{sub}};

  always_comb begin
    acc_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      OP_LOAD: acc_d = data_q;
      OP_ADD, OP_SUB: begin
        acc_d = sum;
        c_d   = cout;
        v_d   = (acc_q[ACC_W-1] == b_eff[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      end
      default: acc_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      data_q      <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b1;
      v_q         <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= in_op;
            data_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          acc_q       <= acc_d;
          c_q         <= c_d;
          v_q         <= v_d;
          z_q         <= (acc_d == '0);
          cnt_q       <= cnt_q + 8'd1;
          out_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;
  assign ops_cnt   = cnt_q;

endmodule
